// File: rtl/pi_switch_datapath_if.sv
// Bundle of packet, arbiter-request and arbiter-select signals around one pi-switch datapath.
// There is no valid/ready handshake: every port carries exactly one packet per cycle, the packet MSB is its valid flag, and nothing ever stalls.
interface pi_switch_datapath_if #(
  parameter int P_W = 32
);
  logic [P_W-1:0] l_in;
  logic [P_W-1:0] r_in;
  logic [P_W-1:0] ul_in;
  logic [P_W-1:0] ur_in;
  logic [P_W-1:0] l_out;
  logic [P_W-1:0] r_out;
  logic [P_W-1:0] ul_out;
  logic [P_W-1:0] ur_out;
  logic [1:0]     d_l;
  logic [1:0]     d_r;
  logic [1:0]     d_ul;
  logic [1:0]     d_ur;
  logic [1:0]     sel_l;
  logic [1:0]     sel_r;
  logic [1:0]     sel_ul;
  logic [1:0]     sel_ur;
  logic           random;
  logic           rand_gen;
  logic [15:0]    lfsr_dbg;

  modport slave (
    input  l_in, r_in, ul_in, ur_in,
    input  sel_l, sel_r, sel_ul, sel_ur,
    input  rand_gen,
    output l_out, r_out, ul_out, ur_out,
    output d_l, d_r, d_ul, d_ur,
    output random, lfsr_dbg
  );

  modport master (
    output l_in, r_in, ul_in, ur_in,
    output sel_l, sel_r, sel_ul, sel_ur,
    output rand_gen,
    input  l_out, r_out, ul_out, ur_out,
    input  d_l, d_r, d_ul, d_ur,
    input  random, lfsr_dbg
  );
endinterface

// File: rtl/pi_switch_datapath.sv
// BFT pi-switch datapath: input registers, direction decode, arbiter-aligned delay line,
// registered 4x4 crossbar and the LFSR feeding the arbiter's random input.
module pi_switch_datapath #(
  parameter int          P_W     = 32,
  parameter int          A_W     = 4,
  parameter int          LEVEL   = 1,
  parameter int          POS     = 0,
  parameter int          ARB_LAT = 5,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  pi_switch_datapath_if.slave  bus
);

  localparam int POS_W = A_W - LEVEL;
  localparam logic [POS_W-1:0] POS_V = POS_W'(POS);

  // Port index inside a quad of packets.
  localparam int PL  = 0;
  localparam int PR  = 1;
  localparam int PUL = 2;
  localparam int PUR = 3;

  typedef logic [P_W-1:0] pkt_t;
  typedef pkt_t [3:0]     quad_t;

  quad_t       s0_d;
  quad_t       s0_q;
  quad_t       dl_d [ARB_LAT];
  quad_t       dl_q [ARB_LAT];
  quad_t       aligned;
  quad_t       out_d;
  quad_t       out_q;
  logic [15:0] lfsr_d;
  logic [15:0] lfsr_q;

  // Direction request: 00 void, 01 left child, 10 right child, 11 up (or turnback on ul/ur).
  function automatic logic [1:0] decode(input pkt_t p);
    logic [A_W-1:0] addr;
    logic [1:0]     dir;
    addr = p[P_W-2 -: A_W];
    dir  = 2'b00;
    if (p[P_W-1]) begin
      if (addr[A_W-1:LEVEL] != POS_V) begin
        dir = 2'b11;
      end else if (addr[LEVEL-1]) begin
        dir = 2'b10;
      end else begin
        dir = 2'b01;
      end
    end
    return dir;
  endfunction

  function automatic pkt_t xbar(input logic [1:0] sel, input quad_t a);
    pkt_t p;
    p = a[PUR];
    case (sel)
      2'b01:   p = a[PL];
      2'b10:   p = a[PR];
      2'b11:   p = a[PUL];
      default: p = a[PUR];
    endcase
    return p;
  endfunction

  always_comb begin
    s0_d = {bus.ur_in, bus.ul_in, bus.r_in, bus.l_in};
  end

  // Stage ARB_LAT-1 of the delay line holds the packets whose requests produced the current sel_*.
  always_comb begin
    dl_d[0] = s0_q;
    for (int i = 1; i < ARB_LAT; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  always_comb begin
    aligned    = dl_q[ARB_LAT-1];
    out_d      = '0;
    out_d[PL]  = xbar(bus.sel_l,  aligned);
    out_d[PR]  = xbar(bus.sel_r,  aligned);
    out_d[PUL] = xbar(bus.sel_ul, aligned);
    out_d[PUR] = xbar(bus.sel_ur, aligned);
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.rand_gen) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q   <= '0;
      out_q  <= '0;
      lfsr_q <= SEED;
      for (int i = 0; i < ARB_LAT; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      s0_q   <= s0_d;
      out_q  <= out_d;
      lfsr_q <= lfsr_d;
      for (int i = 0; i < ARB_LAT; i++) begin
        dl_q[i] <= dl_d[i];
      end
    end
  end

  assign bus.d_l      = decode(s0_q[PL]);
  assign bus.d_r      = decode(s0_q[PR]);
  assign bus.d_ul     = decode(s0_q[PUL]);
  assign bus.d_ur     = decode(s0_q[PUR]);
  assign bus.l_out    = out_q[PL];
  assign bus.r_out    = out_q[PR];
  assign bus.ul_out   = out_q[PUL];
  assign bus.ur_out   = out_q[PUR];
  assign bus.random   = lfsr_q[0];
  assign bus.lfsr_dbg = lfsr_q;

endmodule
